// File: rtl/ip_msx_pkg.sv
// ip_msx_pkg: shared constants for the MSX cartridge mapper blocks.
package ip_msx_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;
  localparam logic [15:0] PAGE0_BASE = 16'h4000;
  localparam logic [15:0] PAGE1_BASE = 16'h6000;
  localparam logic [15:0] PAGE2_BASE = 16'h8000;
  localparam logic [15:0] PAGE3_BASE = 16'hA000;
  localparam logic [15:0] PAGE_SIZE  = 16'h2000;
  localparam logic [4:0] BANK_PREFIX0 = 5'b01100;
  localparam logic [4:0] BANK_PREFIX1 = 5'b01101;
  localparam logic [4:0] BANK_PREFIX2 = 5'b01110;
  localparam logic [4:0] BANK_PREFIX3 = 5'b01111;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
  // Pages 4000h..A000h map to selects 0..3 via address bits [15:13].
  function automatic logic [1:0] page_sel(input logic [2:0] page);
    return 2'(page - 3'd2);
  endfunction
endpackage

// File: rtl/ip_ascii8_bank_regs.sv
// ip_ascii8_bank_regs: four ASCII8 bank registers with write decode and page read mux.
module ip_ascii8_bank_regs
  import ip_msx_pkg::*;
#(
  parameter int BANK_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 wr_en,
  input  logic [4:0]           wr_prefix,
  input  logic [7:0]           wr_data,
  input  logic [1:0]           sel,
  output logic [BANK_BITS-1:0] page_bank
);
  logic [BANK_BITS-1:0] bank_q [4];
  logic [BANK_BITS-1:0] bank_d [4];
  logic                 wr_hit;
  always_comb begin
    wr_hit = wr_en && (wr_prefix[4:2] == BANK_PREFIX0[4:2]);
    bank_d = bank_q;
    if (wr_hit) bank_d[wr_prefix[1:0]] = wr_data[BANK_BITS-1:0];
    page_bank = bank_q[sel];
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) bank_q <= '{default: '0};
    else bank_q <= bank_d;
endmodule

// File: rtl/ip_ascii8_mapper.sv
// ip_ascii8_mapper: ASCII8 MegaROM mapper translating Z80 reads into req/ack ROM fetches.
module ip_ascii8_mapper
  import ip_msx_pkg::*;
#(
  parameter int BANK_BITS = 8,
  parameter int TIMEOUT   = 63
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [15:0]             bus_address,
  input  logic                    bus_memory_read,
  input  logic                    bus_memory_write,
  input  logic [7:0]              bus_write_data,
  output logic                    bus_read_ready,
  output logic [7:0]              bus_read_data,
  output logic [13+BANK_BITS-1:0] mem_address,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic [7:0]              mem_rdata
);
  localparam int AW = 13 + BANK_BITS;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic                 read_q, write_q, rd_start, wr_start, in_range, timed_out;
  logic [1:0]           state_q, state_d, sel;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BANK_BITS-1:0] page_bank;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 req_q, req_d, ready_q, ready_d;
  logic [7:0]           data_q, data_d;
  ip_ascii8_bank_regs #(.BANK_BITS(BANK_BITS)) u_banks (
    .clk      (clk),
    .n_reset  (n_reset),
    .wr_en    (wr_start),
    .wr_prefix(bus_address[15:11]),
    .wr_data  (bus_write_data),
    .sel      (sel),
    .page_bank(page_bank)
  );
  always_comb begin
    rd_start  = bus_memory_read & ~read_q;
    wr_start  = bus_memory_write & ~write_q;
    in_range  = (bus_address >= PAGE0_BASE) && (bus_address < PAGE3_BASE + PAGE_SIZE);
    sel       = page_sel(bus_address[15:13]);
    timed_out = cnt_q == CW'(TIMEOUT);
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    req_d     = req_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE:
        if (rd_start && in_range) begin
          addr_d  = {page_bank, bus_address[12:0]};
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      ST_FETCH:
        if (mem_ack || timed_out) begin
          data_d  = mem_ack ? mem_rdata : TIMEOUT_FILL;
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      ST_RESP:
        state_d = ST_RELEASE;
      default:
        state_d = bus_memory_read ? ST_RELEASE : ST_IDLE;
    endcase
  end
  // Reset drops mem_req immediately; the memory side tolerates abandoned requests.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      read_q  <= bus_memory_read;
      write_q <= bus_memory_write;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  assign bus_read_ready = ready_q;
  assign bus_read_data  = data_q;
  assign mem_address    = addr_q;
  assign mem_req        = req_q;
endmodule

// File: tb/tb_ip_ascii8_mapper.sv
// tb_ip_ascii8_mapper: table-driven vectors plus hand sequences, scoreboarded fetch address and read data.
module tb_ip_ascii8_mapper;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] bus_address = '0;
  logic        bus_memory_read = 1'b0;
  logic        bus_memory_write = 1'b0;
  logic [7:0]  bus_write_data = '0;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [20:0] mem_address;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic req_prev = 1'b0;
  logic [20:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    int          dly;
    bit          fetch;
    logic [20:0] ea;
  } vec_t;

  ip_ascii8_mapper dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .bus_address     (bus_address),
    .bus_memory_read (bus_memory_read),
    .bus_memory_write(bus_memory_write),
    .bus_write_data  (bus_write_data),
    .bus_read_ready  (bus_read_ready),
    .bus_read_data   (bus_read_data),
    .mem_address     (mem_address),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset) begin
      if (mem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got mem_address %0h expected no request", mem_address);
        end else chk("mem_address", 32'(mem_address), 32'(exp_addr_q.pop_front()));
      end
      if (bus_read_ready) begin
        ready_cnt++;
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: got data %0h expected no ready", bus_read_data);
        end else chk("read_data", 32'(bus_read_data), 32'(exp_data_q.pop_front()));
      end
    end
    req_prev = mem_req;
  end

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_address = a; bus_write_data = d; bus_memory_write = 1'b1;
    @(negedge clk);
    bus_memory_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] rd, input int dly, input bit fetch,
                         input logic [20:0] ea, input int hold, output int k);
    int r0;
    r0 = ready_cnt;
    k = 0;
    if (fetch) begin
      exp_addr_q.push_back(ea);
      exp_data_q.push_back(dly < 0 ? 8'hFF : rd);
    end
    @(negedge clk);
    bus_address = a; bus_memory_read = 1'b1;
    @(negedge clk);
    chk("req_raised", 32'(mem_req), 32'(fetch));
    while (mem_req && k < 200) begin
      chk("addr_stable", 32'(mem_address), 32'(ea));
      if (k == dly) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(negedge clk);
      mem_ack = 1'b0;
      k++;
    end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL req_timeout: got mem_req held %0d cycles expected release", k);
    end
    repeat (hold + 1) @(negedge clk);
    bus_memory_read = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_pulses", 32'(ready_cnt - r0), fetch ? 32'd1 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int k, r0;
    vecs = '{
      '{0, 16'h4123, 8'h5A, 1, 1, 21'h00123},
      '{1, 16'h6800, 8'h12, 0, 0, 21'h0},
      '{0, 16'h7FFF, 8'h33, 0, 1, 21'h25FFF},
      '{1, 16'h7800, 8'h3F, 0, 0, 21'h0},
      '{0, 16'hA000, 8'hC3, 2, 1, 21'h7E000},
      '{0, 16'h0000, 8'h00, 0, 0, 21'h0},
      '{0, 16'hC000, 8'h00, 0, 0, 21'h0},
      '{1, 16'h5000, 8'h07, 0, 0, 21'h0},
      '{0, 16'h4000, 8'h11, 0, 1, 21'h00000},
      '{0, 16'h6000, 8'h22, 3, 1, 21'h24000},
      '{0, 16'hBFFF, 8'h44, 0, 1, 21'h7FFFF},
      '{1, 16'hFFFF, 8'h55, 0, 0, 21'h0},
      '{0, 16'h9FFF, 8'h66, 0, 1, 21'h01FFF}
    };
    #3;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ready", 32'(bus_read_ready), 0);
    chk("rst_data", 32'(bus_read_data), 0);
    chk("rst_addr", 32'(mem_address), 0);
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 13; i++)
      if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
      else do_read(vecs[i].a, vecs[i].d, vecs[i].dly, vecs[i].fetch, vecs[i].ea, 2, k);
    // timeout: no ack, data FFh after 64 fetch cycles, read held in release
    do_read(16'h4000, 8'h00, -1, 1, 21'h00000, 6, k);
    chk("timeout_cycles", 32'(k), 32'd64);
    chk("timeout_data_hold", 32'(bus_read_data), 32'hFF);
    r0 = ready_cnt;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h77;
    @(negedge clk); mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ack_data", 32'(bus_read_data), 32'hFF);
    chk("idle_ack_ready", 32'(ready_cnt - r0), 0);
    // bank write while a fetch is stalled
    exp_addr_q.push_back(21'h00000); exp_data_q.push_back(8'h5E);
    @(negedge clk); bus_address = 16'h8000; bus_memory_read = 1'b1;
    @(negedge clk); chk("stall_req", 32'(mem_req), 1);
    bus_address = 16'h7000; bus_write_data = 8'h09; bus_memory_write = 1'b1;
    @(negedge clk); bus_memory_write = 1'b0; bus_address = 16'h8000;
    @(negedge clk); chk("stall_addr", 32'(mem_address), 0);
    chk("stall_req_held", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 8'h5E;
    @(negedge clk); mem_ack = 1'b0;
    repeat (2) @(negedge clk); bus_memory_read = 1'b0;
    repeat (2) @(negedge clk);
    do_read(16'h8000, 8'h61, 0, 1, 21'h12000, 1, k);
    // read strobe drops mid-fetch; response still issued, back to idle
    r0 = ready_cnt;
    exp_addr_q.push_back(21'h00000); exp_data_q.push_back(8'hA5);
    @(negedge clk); bus_address = 16'h4000; bus_memory_read = 1'b1;
    @(negedge clk); chk("abort_req", 32'(mem_req), 1);
    bus_memory_read = 1'b0;
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    @(negedge clk); mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_ready", 32'(ready_cnt - r0), 1);
    do_read(16'h4000, 8'h3C, 0, 1, 21'h00000, 0, k);
    // asynchronous reset mid-fetch
    exp_addr_q.push_back(21'h12000);
    @(negedge clk); bus_address = 16'h8000; bus_memory_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_req", 32'(mem_req), 1);
    #2 n_reset = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 0);
    chk("async_addr", 32'(mem_address), 0);
    chk("async_ready", 32'(bus_read_ready), 0);
    @(negedge clk); bus_memory_read = 1'b0;
    #2 n_reset = 1'b1;
    repeat (2) @(negedge clk);
    do_read(16'h4000, 8'h81, 0, 1, 21'h00000, 1, k);
    do_read(16'h6000, 8'h82, 1, 1, 21'h00000, 1, k);
    do_read(16'hA000, 8'h83, 0, 1, 21'h00000, 1, k);
    chk("queue_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
